// File: rtl/output_port_cluster_arb.sv
// Output-port cluster: per-port payload FIFOs, destination registers, credit
// counters and auto-incrementing addresses, merged by a round-robin arbiter
// into one registered valid/ready packet stream toward the leaf interface.
module output_port_cluster_arb #(
  parameter int NUM_OUT_PORTS   = 7,
  parameter int PAYLOAD_BITS    = 64,
  parameter int NUM_LEAF_BITS   = 6,
  parameter int NUM_PORT_BITS   = 4,
  parameter int NUM_ADDR_BITS   = 7,
  parameter int FIFO_DEPTH_BITS = 2,
  localparam int SEL_BITS       = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1,
  localparam int PACKET_BITS    = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_we,
  input  logic [SEL_BITS-1:0]                   cfg_sel,
  input  logic                                  cfg_en,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
  input  logic [NUM_ADDR_BITS-1:0]              cfg_base_addr,
  input  logic [NUM_ADDR_BITS:0]                cfg_credit,
  input  logic                                  cred_vld,
  input  logic [SEL_BITS-1:0]                   cred_sel,
  input  logic [NUM_ADDR_BITS:0]                cred_amt,
  input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] din,
  input  logic [NUM_OUT_PORTS-1:0]              vld,
  output logic [NUM_OUT_PORTS-1:0]              ack,
  output logic [PACKET_BITS-1:0]                pkt_out,
  output logic                                  pkt_out_vld,
  input  logic                                  pkt_out_rdy,
  output logic [NUM_OUT_PORTS-1:0]              credit_zero
);

  localparam int DEPTH     = 1 << FIFO_DEPTH_BITS;
  localparam int CNT_BITS  = FIFO_DEPTH_BITS + 1;
  localparam int CRED_BITS = NUM_ADDR_BITS + 1;
  localparam logic [CRED_BITS-1:0] CRED_MAX = '1;

  logic [PAYLOAD_BITS-1:0]    fifo_mem [NUM_OUT_PORTS][DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr   [NUM_OUT_PORTS];
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr   [NUM_OUT_PORTS];
  logic [CNT_BITS-1:0]        count    [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0]   enable;
  logic [NUM_LEAF_BITS-1:0]   dst_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]   dst_port [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0]   addr     [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]       credit   [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]       credit_next [NUM_OUT_PORTS];
  logic [CRED_BITS:0]         credit_sum  [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0]   push;
  logic [NUM_OUT_PORTS-1:0]   pop;
  logic [NUM_OUT_PORTS-1:0]   eligible;
  logic [NUM_OUT_PORTS-1:0]   cfg_hit;
  logic [NUM_OUT_PORTS-1:0]   cred_hit;

  logic [SEL_BITS-1:0]        last_grant;
  logic [SEL_BITS-1:0]        grant_idx;
  logic                       grant_any;
  logic                       load;
  logic                       do_grant;

  logic [PAYLOAD_BITS-1:0]    head_payload;
  logic [NUM_LEAF_BITS-1:0]   head_leaf;
  logic [NUM_PORT_BITS-1:0]   head_port;
  logic [NUM_ADDR_BITS-1:0]   head_addr;

  // Per-port status: ack comes only from the registered count, never from vld
  always_comb begin
    ack         = '0;
    push        = '0;
    eligible    = '0;
    credit_zero = '0;
    cfg_hit     = '0;
    cred_hit    = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      ack[i]         = (count[i] != CNT_BITS'(DEPTH));
      push[i]        = vld[i] && (count[i] != CNT_BITS'(DEPTH));
      eligible[i]    = enable[i] && (count[i] != '0) && (credit[i] != '0);
      credit_zero[i] = (credit[i] == '0);
      cfg_hit[i]     = cfg_we && (cfg_sel == SEL_BITS'(i));
      cred_hit[i]    = cred_vld && (cred_sel == SEL_BITS'(i));
    end
  end

  // Round-robin search: ports above last_grant first, then wrap from port 0
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!grant_any && eligible[i] && (SEL_BITS'(i) > last_grant)) begin
        grant_any = 1'b1;
        grant_idx = SEL_BITS'(i);
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (!grant_any && eligible[i] && (SEL_BITS'(i) <= last_grant)) begin
        grant_any = 1'b1;
        grant_idx = SEL_BITS'(i);
      end
    end
  end

  // Output register may reload when empty or when the current packet leaves
  always_comb begin
    load     = !pkt_out_vld || pkt_out_rdy;
    do_grant = load && grant_any;
    pop      = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (do_grant && (grant_idx == SEL_BITS'(i))) begin
        pop[i] = 1'b1;
      end
    end
  end

  // Select the head entry and destination fields of the granted port
  always_comb begin
    head_payload = '0;
    head_leaf    = '0;
    head_port    = '0;
    head_addr    = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_idx == SEL_BITS'(i)) begin
        head_payload = fifo_mem[i][rd_ptr[i]];
        head_leaf    = dst_leaf[i];
        head_port    = dst_port[i];
        head_addr    = addr[i];
      end
    end
  end

  // Next credit: add any return, take one for a grant, saturate at the top
  always_comb begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      credit_sum[i] = {1'b0, credit[i]}
                    + (cred_hit[i] ? {1'b0, cred_amt} : '0)
                    - (pop[i] ? (CRED_BITS+1)'(1) : '0);
      if (credit_sum[i] > {1'b0, CRED_MAX}) begin
        credit_next[i] = CRED_MAX;
      end else begin
        credit_next[i] = credit_sum[i][CRED_BITS-1:0];
      end
    end
  end

  // FIFO storage is not reset; emptiness is tracked by the counters alone
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (push[i]) begin
        fifo_mem[i][wr_ptr[i]] <= din[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= wr_ptr[i] + FIFO_DEPTH_BITS'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + FIFO_DEPTH_BITS'(1);
        end
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_BITS'(1);
          2'b01:   count[i] <= count[i] - CNT_BITS'(1);
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  // Port configuration wins over same-cycle grant and credit-return updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        dst_leaf[i] <= '0;
        dst_port[i] <= '0;
        addr[i]     <= '0;
        credit[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (cfg_hit[i]) begin
          enable[i]   <= cfg_en;
          dst_leaf[i] <= cfg_dst_leaf;
          dst_port[i] <= cfg_dst_port;
          addr[i]     <= cfg_base_addr;
          credit[i]   <= cfg_credit;
        end else begin
          if (pop[i]) begin
            addr[i] <= addr[i] + NUM_ADDR_BITS'(1);
          end
          credit[i] <= credit_next[i];
        end
      end
    end
  end

  // Registered packet output; holds its value while stalled or idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_out     <= '0;
      pkt_out_vld <= 1'b0;
      last_grant  <= '0;
    end else if (load) begin
      if (grant_any) begin
        pkt_out     <= {1'b1, head_leaf, head_port, head_addr, head_payload};
        pkt_out_vld <= 1'b1;
        last_grant  <= grant_idx;
      end else begin
        pkt_out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_output_port_cluster_arb.sv
// Scoreboard bench for output_port_cluster_arb: directed stimulus pushes
// hand-computed packets into a queue, a negedge monitor pops and compares.
module tb_output_port_cluster_arb;

  localparam int N   = 7;
  localparam int PB  = 64;
  localparam int PKT = 82;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_we;
  logic [2:0]     cfg_sel;
  logic           cfg_en;
  logic [5:0]     cfg_dst_leaf;
  logic [3:0]     cfg_dst_port;
  logic [6:0]     cfg_base_addr;
  logic [7:0]     cfg_credit;
  logic           cred_vld;
  logic [2:0]     cred_sel;
  logic [7:0]     cred_amt;
  logic [PB*N-1:0] din;
  logic [N-1:0]   vld;
  logic [N-1:0]   ack;
  logic [PKT-1:0] pkt_out;
  logic           pkt_out_vld;
  logic           pkt_out_rdy;
  logic [N-1:0]   credit_zero;

  int tests  = 0;
  int failed = 0;
  logic [PKT-1:0] exp_q[$];
  logic [PKT-1:0] mon_exp;

  output_port_cluster_arb dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
    .cfg_dst_leaf(cfg_dst_leaf), .cfg_dst_port(cfg_dst_port),
    .cfg_base_addr(cfg_base_addr), .cfg_credit(cfg_credit),
    .cred_vld(cred_vld), .cred_sel(cred_sel), .cred_amt(cred_amt),
    .din(din), .vld(vld), .ack(ack),
    .pkt_out(pkt_out), .pkt_out_vld(pkt_out_vld), .pkt_out_rdy(pkt_out_rdy),
    .credit_zero(credit_zero)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic logic [PB-1:0] pay(input int i, input int k);
    return {16'hC0DE, 16'(i), 32'(k)};
  endfunction

  function automatic logic [PKT-1:0] mk_pkt(input logic [5:0] leaf, input logic [3:0] port,
                                           input logic [6:0] a, input logic [PB-1:0] p);
    return {1'b1, leaf, port, a, p};
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input int k);
    vld = v;
    for (int i = 0; i < N; i++) din[i*PB +: PB] = pay(i, k);
    step();
    vld = '0;
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic en, input logic [5:0] leaf,
                           input logic [3:0] port, input logic [6:0] base, input logic [7:0] cred);
    cfg_sel = sel; cfg_en = en; cfg_dst_leaf = leaf; cfg_dst_port = port;
    cfg_base_addr = base; cfg_credit = cred; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic cred_return(input logic [2:0] sel, input logic [7:0] amt);
    cred_sel = sel; cred_amt = amt; cred_vld = 1'b1;
    step();
    cred_vld = 1'b0;
  endtask

  // Monitor: every accepted output packet must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && pkt_out_vld && pkt_out_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("[TB] FAIL unexpected_pkt actual=%h required=none", pkt_out);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("pkt", 128'(pkt_out), 128'(mon_exp));
      end
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence
  initial begin
    reset = 1'b1; cfg_we = 0; cfg_sel = 0; cfg_en = 0; cfg_dst_leaf = 0; cfg_dst_port = 0;
    cfg_base_addr = 0; cfg_credit = 0; cred_vld = 0; cred_sel = 0; cred_amt = 0;
    din = '0; vld = '0; pkt_out_rdy = 1'b0;
    step(); step();
    checkOutput("rst_ack", 128'(ack), 128'(7'h7F));
    checkOutput("rst_vld", 128'(pkt_out_vld), 128'(0));
    checkOutput("rst_pkt", 128'(pkt_out), 128'(0));
    checkOutput("rst_czero", 128'(credit_zero), 128'(7'h7F));
    reset = 1'b0;
    step();

    // Address wrap and first-packet latency on port 0
    pkt_out_rdy = 1'b1;
    cfg_write(3'd0, 1'b1, 6'd5, 4'd3, 7'h7E, 8'd4);
    exp_q.push_back(mk_pkt(6'd5, 4'd3, 7'h7E, pay(0, 0)));
    exp_q.push_back(mk_pkt(6'd5, 4'd3, 7'h7F, pay(0, 1)));
    exp_q.push_back(mk_pkt(6'd5, 4'd3, 7'h00, pay(0, 2)));
    applyStimulus(7'b0000001, 0);
    checkOutput("lat_t", 128'(pkt_out_vld), 128'(0));
    applyStimulus(7'b0000001, 1);
    checkOutput("lat_t1", 128'(pkt_out_vld), 128'(1));
    applyStimulus(7'b0000001, 2);
    repeat (4) step();
    checkOutput("t1_czero", 128'(credit_zero), 128'(7'b1111110));
    checkOutput("t1_idle", 128'(pkt_out_vld), 128'(0));

    // Fill disabled ports 0..2, stall output, then strict rotation at full rate
    cfg_write(3'd0, 1'b0, 6'd0, 4'd0, 7'h00, 8'd0);
    for (int k = 0; k < 4; k++) applyStimulus(7'b0000111, k);
    checkOutput("full_ack", 128'(ack), 128'(7'b1111000));
    pkt_out_rdy = 1'b0;
    cfg_write(3'd2, 1'b1, 6'd12, 4'd2, 7'h10, 8'd8);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) exp_q.push_back(mk_pkt(6'd10, 4'd0, 7'(8'h20 + k - 1), pay(0, k - 1)));
      if (k > 0) exp_q.push_back(mk_pkt(6'd11, 4'd1, 7'(8'h30 + k - 1), pay(1, k - 1)));
      exp_q.push_back(mk_pkt(6'd12, 4'd2, 7'(8'h10 + k), pay(2, k)));
    end
    exp_q.push_back(mk_pkt(6'd10, 4'd0, 7'h23, pay(0, 3)));
    exp_q.push_back(mk_pkt(6'd11, 4'd1, 7'h33, pay(1, 3)));
    step();
    checkOutput("stall_0", 128'(pkt_out), 128'(mk_pkt(6'd12, 4'd2, 7'h10, pay(2, 0))));
    checkOutput("pop_ack", 128'(ack), 128'(7'b1111100));
    cfg_write(3'd0, 1'b1, 6'd10, 4'd0, 7'h20, 8'd8);
    checkOutput("stall_1", 128'(pkt_out), 128'(mk_pkt(6'd12, 4'd2, 7'h10, pay(2, 0))));
    cfg_write(3'd1, 1'b1, 6'd11, 4'd1, 7'h30, 8'd8);
    checkOutput("stall_2", 128'(pkt_out), 128'(mk_pkt(6'd12, 4'd2, 7'h10, pay(2, 0))));
    for (int c = 3; c < 5; c++) begin
      step();
      checkOutput($sformatf("stall_%0d", c), 128'(pkt_out), 128'(mk_pkt(6'd12, 4'd2, 7'h10, pay(2, 0))));
    end
    checkOutput("stall_vld", 128'(pkt_out_vld), 128'(1));
    pkt_out_rdy = 1'b1;
    repeat (12) step();
    checkOutput("drain_rate", 128'(exp_q.size()), 128'(0));
    checkOutput("drain_idle", 128'(pkt_out_vld), 128'(0));

    // Credit of one stalls the second payload until credit returns
    cfg_write(3'd3, 1'b1, 6'd7, 4'd9, 7'h05, 8'd1);
    exp_q.push_back(mk_pkt(6'd7, 4'd9, 7'h05, pay(3, 0)));
    applyStimulus(7'b0001000, 0);
    applyStimulus(7'b0001000, 1);
    repeat (3) step();
    checkOutput("cred_stall_cz", 128'(credit_zero), 128'(7'b1111000));
    checkOutput("cred_stall_vld", 128'(pkt_out_vld), 128'(0));
    exp_q.push_back(mk_pkt(6'd7, 4'd9, 7'h06, pay(3, 1)));
    cred_return(3'd3, 8'd3);
    repeat (2) step();
    checkOutput("cred_ret_cz", 128'(credit_zero), 128'(7'b1110000));
    exp_q.push_back(mk_pkt(6'd7, 4'd9, 7'h07, pay(3, 2)));
    exp_q.push_back(mk_pkt(6'd7, 4'd9, 7'h08, pay(3, 3)));
    applyStimulus(7'b0001000, 2);
    applyStimulus(7'b0001000, 3);
    repeat (3) step();
    checkOutput("cred_two_cz", 128'(credit_zero), 128'(7'b1111000));

    // Grant and credit return on port 2 in the same cycle: 3 + 2 - 1 = 4
    cfg_write(3'd2, 1'b1, 6'd12, 4'd2, 7'h40, 8'd3);
    for (int k = 0; k < 5; k++) exp_q.push_back(mk_pkt(6'd12, 4'd2, 7'(8'h40 + k), pay(2, 10 + k)));
    applyStimulus(7'b0000100, 10);
    cred_sel = 3'd2; cred_amt = 8'd2; cred_vld = 1'b1;
    applyStimulus(7'b0000100, 11);
    cred_vld = 1'b0;
    for (int k = 12; k < 16; k++) applyStimulus(7'b0000100, k);
    repeat (3) step();
    checkOutput("same_cyc_cz", 128'(credit_zero), 128'(7'b1111100));
    checkOutput("same_cyc_vld", 128'(pkt_out_vld), 128'(0));

    // Saturation: 1 + 255 clamps to 255, and 255 + 255 stays 255
    cfg_write(3'd4, 1'b1, 6'd1, 4'd1, 7'h00, 8'd1);
    cred_return(3'd4, 8'd255);
    checkOutput("sat_cz", 128'(credit_zero), 128'(7'b1101100));
    cred_return(3'd4, 8'd255);
    for (int k = 0; k < 256; k++) begin
      if (k < 255) exp_q.push_back(mk_pkt(6'd1, 4'd1, 7'(k), pay(4, 100 + k)));
      applyStimulus(7'b0010000, 100 + k);
    end
    repeat (3) step();
    checkOutput("sat_spent_cz", 128'(credit_zero), 128'(7'b1111100));

    // Out-of-range select is ignored for config and credit
    cfg_write(3'd7, 1'b1, 6'd1, 4'd1, 7'h00, 8'd50);
    cred_return(3'd7, 8'd9);
    step();
    checkOutput("oor_sel_cz", 128'(credit_zero), 128'(7'b1111100));
    checkOutput("sb_empty", 128'(exp_q.size()), 128'(0));

    // Asynchronous reset while a packet is held and FIFOs are occupied
    pkt_out_rdy = 1'b0;
    cfg_write(3'd5, 1'b1, 6'd3, 4'd3, 7'h11, 8'd4);
    for (int k = 200; k < 203; k++) applyStimulus(7'b0100000, k);
    checkOutput("pre_rst_vld", 128'(pkt_out_vld), 128'(1));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_vld", 128'(pkt_out_vld), 128'(0));
    checkOutput("async_pkt", 128'(pkt_out), 128'(0));
    checkOutput("async_ack", 128'(ack), 128'(7'h7F));
    checkOutput("async_cz", 128'(credit_zero), 128'(7'h7F));
    pkt_out_rdy = 1'b1;
    step(); step();
    reset = 1'b0;
    repeat (10) step();
    checkOutput("post_rst_vld", 128'(pkt_out_vld), 128'(0));
    checkOutput("final_sb", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
